// File: rtl/alu_7seg_scan_if.sv
// alu_7seg_scan_if: operand/opcode inputs and display/flag outputs of the ALU display
interface alu_7seg_scan_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]  in_1;
    logic [WIDTH-1:0]  in_2;
    logic [2:0]        sel;
    logic              En;
    logic [7:0]        out;
    logic [DIGITS-1:0] an;
    logic              valid;
    logic              carry;
    logic              zero;
    modport master (output in_1, in_2, sel, En, input out, an, valid, carry, zero);
    modport slave  (input in_1, in_2, sel, En, output out, an, valid, carry, zero);
endinterface

// File: rtl/alu_7seg_scan.sv
// alu_7seg_scan: registered ALU result shown in hex on a scanned 7-segment bank
module alu_7seg_scan #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 4
) (
    input logic clk,
    input logic rst,
    alu_7seg_scan_if.slave bus
);
    localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    // glyphs gfedcba, entry 0 in the low bits
    localparam logic [16*7-1:0] FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    if (DIGITS * 4 < WIDTH + 1 || SCAN_DIV < 1) begin : g_bad_params
        $error("alu_7seg_scan: need DIGITS*4 >= WIDTH+1 and SCAN_DIV >= 1");
    end
    logic [PW-1:0]         p;
    logic [DW-1:0]         d;
    logic [WIDTH:0]        r;
    logic [WIDTH:0]        res;
    logic                  vld;
    logic [DIGITS*4-1:0]   dv;
    logic [DIGITS*4-1:0]   up;
    logic [3:0]            nib;
    logic                  blank;
    always_comb begin
        r = bus.sel == 3'd0 ? {1'b0, bus.in_1} + {1'b0, bus.in_2} :
            bus.sel == 3'd1 ? {1'b0, bus.in_1} - {1'b0, bus.in_2} :
            bus.sel == 3'd2 ? {1'b0, bus.in_1 & bus.in_2} :
            bus.sel == 3'd3 ? {1'b0, bus.in_1 | bus.in_2} :
            bus.sel == 3'd4 ? {1'b0, bus.in_1 ^ bus.in_2} :
            bus.sel == 3'd5 ? {1'b0, ~bus.in_1} :
            bus.sel == 3'd6 ? {bus.in_1, 1'b0} :
                              {bus.in_1[0], 1'b0, bus.in_1[WIDTH-1:1]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            p   <= '0;
            d   <= '0;
            res <= '0;
            vld <= 1'b0;
        end else begin
            p <= p == PW'(SCAN_DIV - 1) ? '0 : p + 1'b1;
            if (p == PW'(SCAN_DIV - 1))
                d <= d == DW'(DIGITS - 1) ? '0 : d + 1'b1;
            if (bus.En) begin
                res <= r;
                vld <= 1'b1;
            end
        end
    end
    // a digit blanks when it and every more significant nibble are zero
    always_comb begin
        dv    = (DIGITS*4)'(res);
        up    = dv >> {d, 2'b00};
        nib   = up[3:0];
        blank = d != '0 && up == '0;
    end
    assign bus.valid = vld;
    assign bus.carry = res[WIDTH];
    assign bus.zero  = res[WIDTH-1:0] == '0;
    assign bus.an    = ~(DIGITS'(1) << d);
    assign bus.out   = !vld ? 8'h00 :
                       {d == '0 && bus.zero, blank ? 7'h00 : FONT[int'(nib)*7 +: 7]};
endmodule

// File: tb/tb_alu_7seg_scan.sv
// tb_alu_7seg_scan: table-driven check of ALU capture, flags, blanking and scanning
module tb_alu_7seg_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_7seg_scan_if #(.WIDTH(8), .DIGITS(4)) bus();
    alu_7seg_scan #(.WIDTH(8), .DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic        c;
        logic        z;
        logic [31:0] segs;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    vec_t v[9];

    // free-running model of the scanner: p = cyc%4, d = (cyc/4)%4
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic scan_check(input int n, input logic [31:0] segs, input logic vld);
        int ed;
        logic [3:0] ea;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ed = (cyc / 4) % 4;
            ea = ~(4'b0001 << ed);
            check("an", 32'(bus.an), 32'(ea));
            check("out", 32'(bus.out), 32'(segs[ed*8 +: 8]));
            check("valid", 32'(bus.valid), 32'(vld));
        end
    endtask

    initial begin
        v[0] = '{8'h07, 8'h05, 3'd0, 1'b0, 1'b0, 32'h0000_0039};
        v[1] = '{8'h05, 8'h0A, 3'd1, 1'b1, 1'b0, 32'h0006_717C};
        v[2] = '{8'h0B, 8'h0B, 3'd4, 1'b0, 1'b1, 32'h0000_00BF};
        v[3] = '{8'h81, 8'h00, 3'd6, 1'b1, 1'b0, 32'h0006_3F5B};
        v[4] = '{8'h81, 8'h00, 3'd7, 1'b1, 1'b0, 32'h0006_663F};
        v[5] = '{8'hFF, 8'h0F, 3'd2, 1'b0, 1'b0, 32'h0000_0071};
        v[6] = '{8'hA0, 8'h05, 3'd3, 1'b0, 1'b0, 32'h0000_776D};
        v[7] = '{8'hFF, 8'h00, 3'd5, 1'b0, 1'b1, 32'h0000_00BF};
        v[8] = '{8'hFF, 8'h01, 3'd0, 1'b1, 1'b1, 32'h0006_3FBF};
        bus.in_1 = '0;
        bus.in_2 = '0;
        bus.sel  = '0;
        bus.En   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_an", 32'(bus.an), 32'h0000_000E);
        check("rst_out", 32'(bus.out), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_carry", 32'(bus.carry), 32'h0);
        check("rst_zero", 32'(bus.zero), 32'h1);
        scan_check(20, 32'h0, 1'b0);

        // capture each vector, then scramble inputs with En low to prove the hold
        for (int i = 0; i < 9; i++) begin
            bus.in_1 = v[i].a;
            bus.in_2 = v[i].b;
            bus.sel  = v[i].op;
            bus.En   = 1'b1;
            @(negedge clk);
            bus.En   = 1'b0;
            bus.in_1 = ~v[i].a ^ 8'h35;
            bus.in_2 = v[i].b + 8'h17;
            bus.sel  = v[i].op + 3'd3;
            check("valid", 32'(bus.valid), 32'h1);
            check("carry", 32'(bus.carry), 32'(v[i].c));
            check("zero", 32'(bus.zero), 32'(v[i].z));
            scan_check(16, v[i].segs, 1'b1);
            check("hold_carry", 32'(bus.carry), 32'(v[i].c));
        end

        // En held high over two edges: the second capture wins
        bus.in_1 = 8'h07; bus.in_2 = 8'h05; bus.sel = 3'd0; bus.En = 1'b1;
        @(negedge clk);
        check("first_carry", 32'(bus.carry), 32'h0);
        bus.in_1 = 8'hFF; bus.in_2 = 8'h01;
        @(negedge clk);
        bus.En = 1'b0;
        check("last_wins_carry", 32'(bus.carry), 32'h1);
        check("last_wins_zero", 32'(bus.zero), 32'h1);
        scan_check(8, 32'h0006_3FBF, 1'b1);

        // reset while d=2, p=1 with a result on display
        for (int k = 0; k < 16 && (cyc % 16) != 9; k++) @(negedge clk);
        check("midscan_reach", 32'(cyc % 16), 32'd9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_an", 32'(bus.an), 32'h0000_000E);
        check("midrst_out", 32'(bus.out), 32'h0);
        check("midrst_valid", 32'(bus.valid), 32'h0);
        check("midrst_carry", 32'(bus.carry), 32'h0);
        check("midrst_zero", 32'(bus.zero), 32'h1);
        scan_check(8, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
